serial_subtractor4: RTL

- Bit-serial, LSB-first sequential subtractor computing diff = a - b - b_in over WIDTH clocks.
- Uses one full-subtractor cell and a registered borrow.
- Inverse-operation companion to the combinational 4-bit ripple adder.
- Provides a compact start/busy/done datapath unit for the adder/subtractor lab top level, with unsigned borrow and signed overflow flags.

---
 rtl/serial_subtractor4.sv | 122 ++++++++++++
 1 files changed

// File: rtl/serial_subtractor4.sv
// ---------------------------------------------------------------------------
// serial_subtractor4
//
// Bit-serial, LSB-first subtractor: diff = a - b - b_in, one bit per clock,
// using a single full-subtractor cell and a registered borrow. An operation
// takes WIDTH shift steps after the start is accepted.
//
// Ports:
//   clk     - system clock, rising edge
//   rst_n   - asynchronous active-low reset
//   start   - request, sampled only while busy=0
//   a       - minuend, latched on accepted start
//   b       - subtrahend, latched on accepted start
//   b_in    - borrow-in, latched on accepted start
//   busy    - high while an operation is in flight
//   done    - one-cycle completion pulse
//   diff    - result, held until the next completion
//   borrow  - unsigned borrow-out (a < b + b_in)
//   ovf     - signed two's-complement overflow of a - b - b_in
// ---------------------------------------------------------------------------
module serial_subtractor4 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             br;
    logic [CW-1:0]    cnt;

    logic             a_i;
    logic             b_i;
    logic             d;
    logic             br_next;
    logic [WIDTH-1:0] res_next;
    logic             last_step;

    // Full-subtractor cell on the operand LSBs and the registered borrow.
    // The new difference bit enters at the MSB so that after WIDTH steps the
    // first (LSB) bit has shifted all the way down to bit 0.
    always_comb begin
        a_i       = a_sh[0];
        b_i       = b_sh[0];
        d         = a_i ^ b_i ^ br;
        br_next   = (~a_i & b_i) | (~(a_i ^ b_i) & br);
        res_next  = {d, res_sh[WIDTH-1:1]};
        last_step = (cnt == CW'(WIDTH - 1));
    end

    // Control and datapath registers. done defaults low every edge so it is
    // a single-cycle pulse. On the MSB step, br still holds the borrow into
    // the MSB, so br ^ br_next is the signed overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        br     <= b_in;
                        res_sh <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= res_next;
                    br     <= br_next;
                    cnt    <= cnt + CW'(1);
                    if (last_step) begin
                        diff   <= res_next;
                        borrow <= br_next;
                        ovf    <= br ^ br_next;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        cnt    <= '0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
